munoc_lane_distributor: RTL and testbench
=========================================

# munoc_lane_distributor

Single-clock write-side distributor for the MUNOC fabric. It accepts one write stream and spreads accepted words over `NUM_LANE` per-lane synchronous FIFOs in round-robin order, exposing an independent valid/ready read port per lane. It is the same-clock, parametrised successor of the asynchronous round-robin lane buffer. It adds selectable strict or skip-full arbitration, a reported target lane, per-lane occupancy and an explicit pointer re-initialisation.

## Interface
Parameters:
- `BW_DATA`, 32, data width per word.
- `NUM_LANE`, 4, lane count, ≥1.
- `DEPTH`, 4, entries per lane FIFO, ≥1.
- `SKIP_FULL`, 0, arbitration mode. 0: strict round-robin, the writer waits for the pointed lane. 1: the first non-full lane at or after the pointer is used.
- Derived: `BW_LANE` = clog2(max(`NUM_LANE`,2)); `BW_COUNT` = clog2(`DEPTH`+1).

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `init` input 1: returns the round-robin pointer to lane 0. FIFO contents are kept.
- `wrequest` input 1: the write side offers `wdata`.
- `wready` output 1: a write is accepted this cycle if `wrequest` is also high.
- `wdata` input `BW_DATA`: write word.
- `wlane` output `BW_LANE`: index of the lane that would take or takes the word this cycle. Valid only when `wready`=1.
- `rready` output `NUM_LANE`: bit i high means lane i is non-empty and `rdata` slice i is valid.
- `rrequest` input `NUM_LANE`: bit i pops lane i when `rready`[i] is also high.
- `rdata` output `NUM_LANE*BW_DATA`: head word per lane. Lane i uses bits [`BW_DATA`*(i+1)-1 -: `BW_DATA`].
- `rcount` output `NUM_LANE*BW_COUNT`: occupancy per lane, packed the same way as `rdata`.

## Operation
- State consists of a one-hot pointer `ptr` (`NUM_LANE` bits) and, per lane, a FIFO with read index, write index and count.
- Lane selection is combinational from `ptr` and the full flags.
  - Strict mode: sel = ptr; `wready` = !full[ptr].
  - Skip mode: sel = first lane j, searching circularly from ptr, with !full[j]; `wready` = any lane not full.
- `wready` is forced to 0 while `rst` or `init` is high.
- Accept (`wrequest`&`wready`):
  - The word is pushed into lane sel.
  - ptr becomes one-hot of (sel+1) mod `NUM_LANE`.
  - With `NUM_LANE`=1, ptr stays at lane 0.
- No accept: ptr holds. This applies to both modes; skip mode never rotates without a write.
- `init`=1: ptr becomes lane 0 on the next edge. No write is accepted in that cycle.
- Read side, per lane:
  - Show-ahead FIFO; `rready`[i] = count[i]≠0.
  - A pop (`rrequest`[i]&`rready`[i]) advances the read index. A request on an empty lane is ignored.
- Same lane, same cycle:
  - Push and pop together: count unchanged, both indices advance.
  - A full lane rejects a push even if it is popped in the same cycle. There is no full-bypass.
  - An empty lane being pushed does not show the word until the next cycle. There is no empty-bypass.
- Index wrap: each index wraps from `DEPTH`-1 to 0. Counts saturate in neither direction, because the full and empty gating prevents overflow and underflow.
- Reset values (registered, applied on the edge with `rst`=1):
  - ptr = lane 0.
  - All counts 0, so `rready`=0 and `rcount`=0.
  - `rdata` is don't-care but stable.
  - `wready`=0 while `rst` is high and `wlane`=0.
- `rst` asserted mid-operation discards all buffered words in one cycle.

## Timing
- Write acceptance is single-cycle. `wready` and `wlane` depend combinationally on registered state, `rst` and `init` only. They never depend on `wrequest`, `wdata` or `rrequest`.
- Write-to-read latency is 1 cycle: a word accepted at edge n gives `rready`[sel]=1 and valid `rdata` after edge n.
- `rcount` and `rready` update on the same edge as the push or pop that changes them.
- Throughput is one write per cycle total and one read per cycle per lane.
- There are no combinational paths from `rrequest` to any output in the same cycle.

## Test plan
- Reset then stream, `NUM_LANE`=4, `DEPTH`=2, strict mode: write 0xA0..0xA7 back-to-back with no reads. Required: `wlane` sequence 0,1,2,3,0,1,2,3; every lane ends with `rcount`=2; the next write sees `wready`=0 with `wlane`=0.
- Strict stall: fill lane 1 only (other lanes drained) with the pointer at 1. Required: `wready`=0 until lane 1 is popped. The pop cycle itself still shows `wready`=0; the next cycle shows `wready`=1 and `wlane`=1.
- Skip mode, same fill: lanes 1 and 2 full, pointer at 1. Required: `wready`=1, `wlane`=3; after the accept the pointer is at 0.
- `init` during traffic: pointer at 2, pulse `init` with `wrequest`=1. Required: no accept that cycle; the next write goes to lane 0; FIFO contents and `rcount` are unchanged.
- Concurrent push and pop on one lane at `rcount`=1. Required: `rcount` stays 1; `rdata` takes the newly pushed word after the edge; across 2·`DEPTH` such cycles the order is preserved through index wrap.
- Mid-operation reset with all lanes partially filled. Required: one cycle later all `rready`=0 and `rcount`=0; `wready`=0 during reset and 1 afterwards, with `wlane`=0.

Source files
------------

// File: rtl/munoc_lane_distributor_if.sv
// munoc_lane_distributor_if: write stream plus per-lane read ports of the lane distributor
// Ports: wrequest/wready/wdata/wlane (write side), rready/rrequest/rdata/rcount (packed per-lane read side)
interface munoc_lane_distributor_if #(
    parameter int BW_DATA = 32,
    parameter int NUM_LANE = 4,
    parameter int DEPTH = 4
);
    localparam int BW_LANE = $clog2(NUM_LANE > 2 ? NUM_LANE : 2);
    localparam int BW_COUNT = $clog2(DEPTH + 1);
    logic wrequest;
    logic wready;
    logic [BW_DATA-1:0] wdata;
    logic [BW_LANE-1:0] wlane;
    logic [NUM_LANE-1:0] rready;
    logic [NUM_LANE-1:0] rrequest;
    logic [NUM_LANE*BW_DATA-1:0] rdata;
    logic [NUM_LANE*BW_COUNT-1:0] rcount;
    modport master (output wrequest, wdata, rrequest, input wready, wlane, rready, rdata, rcount);
    modport slave (input wrequest, wdata, rrequest, output wready, wlane, rready, rdata, rcount);
endinterface

// File: rtl/munoc_lane_distributor.sv
// munoc_lane_distributor: round-robin spread of one write stream over NUM_LANE show-ahead FIFOs
// Ports: clk, rst (sync, active-high), init (pointer back to lane 0), bus (slave side of the lane interface)
module munoc_lane_distributor #(
    parameter int BW_DATA = 32,
    parameter int NUM_LANE = 4,
    parameter int DEPTH = 4,
    parameter int SKIP_FULL = 0
) (
    input logic clk,
    input logic rst,
    input logic init,
    munoc_lane_distributor_if.slave bus
);
    localparam int BW_LANE = $clog2(NUM_LANE > 2 ? NUM_LANE : 2);
    localparam int BW_COUNT = $clog2(DEPTH + 1);
    localparam int BW_IDX = $clog2(DEPTH > 2 ? DEPTH : 2);
    logic [NUM_LANE-1:0] ptr;
    logic [BW_DATA-1:0] mem [NUM_LANE][DEPTH];
    logic [BW_IDX-1:0] rd_idx [NUM_LANE];
    logic [BW_IDX-1:0] wr_idx [NUM_LANE];
    logic [BW_COUNT-1:0] count [NUM_LANE];
    logic [NUM_LANE-1:0] full;
    logic [NUM_LANE-1:0] push;
    logic [NUM_LANE-1:0] pop;
    logic [BW_LANE-1:0] ptr_idx;
    logic [BW_LANE-1:0] sel;
    logic [BW_LANE-1:0] nxt;
    logic found;
    logic accept;
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < NUM_LANE; i++)
            if (ptr[i]) ptr_idx = BW_LANE'(i);
        for (int i = 0; i < NUM_LANE; i++)
            full[i] = count[i] == BW_COUNT'(DEPTH);
        sel = ptr_idx;
        found = 1'b0;
        // skip mode: nearest non-full lane walking circularly from the pointer
        if (SKIP_FULL != 0)
            for (int k = 0; k < NUM_LANE; k++)
                if (!found && !full[(int'(ptr_idx) + k) % NUM_LANE]) begin
                    sel = BW_LANE'((int'(ptr_idx) + k) % NUM_LANE);
                    found = 1'b1;
                end
        bus.wready = !rst && !init && (SKIP_FULL != 0 ? |(~full) : !full[ptr_idx]);
        bus.wlane = bus.wready ? sel : '0;
        accept = bus.wrequest && bus.wready;
        nxt = sel == BW_LANE'(NUM_LANE - 1) ? '0 : sel + BW_LANE'(1);
        bus.rdata = '0;
        bus.rcount = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            push[i] = accept && sel == BW_LANE'(i);
            pop[i] = bus.rrequest[i] && count[i] != '0;
            bus.rready[i] = count[i] != '0;
            bus.rdata[BW_DATA*i +: BW_DATA] = mem[i][rd_idx[i]];
            bus.rcount[BW_COUNT*i +: BW_COUNT] = count[i];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= NUM_LANE'(1);
            for (int i = 0; i < NUM_LANE; i++) begin
                rd_idx[i] <= '0;
                wr_idx[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            if (init) ptr <= NUM_LANE'(1);
            else if (accept) ptr <= NUM_LANE'(1) << nxt;
            for (int i = 0; i < NUM_LANE; i++) begin
                if (push[i]) wr_idx[i] <= wr_idx[i] == BW_IDX'(DEPTH - 1) ? '0 : wr_idx[i] + BW_IDX'(1);
                if (pop[i]) rd_idx[i] <= rd_idx[i] == BW_IDX'(DEPTH - 1) ? '0 : rd_idx[i] + BW_IDX'(1);
                count[i] <= count[i] + BW_COUNT'(push[i]) - BW_COUNT'(pop[i]);
            end
        end
    end
    // storage carries no reset; a cleared count hides stale words
    always_ff @(posedge clk)
        for (int i = 0; i < NUM_LANE; i++)
            if (push[i]) mem[i][wr_idx[i]] <= bus.wdata;
endmodule

// File: tb/tb_munoc_lane_distributor.sv
// tb_munoc_lane_distributor: directed checks of strict and skip-full lane distribution
module tb_munoc_lane_distributor;
    logic clk;
    logic rst;
    logic init;
    int errors = 0;
    int checks = 0;
    munoc_lane_distributor_if #(.BW_DATA(32), .NUM_LANE(4), .DEPTH(2)) bs ();
    munoc_lane_distributor_if #(.BW_DATA(32), .NUM_LANE(4), .DEPTH(2)) bk ();
    munoc_lane_distributor #(.BW_DATA(32), .NUM_LANE(4), .DEPTH(2), .SKIP_FULL(0)) u_strict (
        .clk(clk), .rst(rst), .init(init), .bus(bs)
    );
    munoc_lane_distributor #(.BW_DATA(32), .NUM_LANE(4), .DEPTH(2), .SKIP_FULL(1)) u_skip (
        .clk(clk), .rst(rst), .init(init), .bus(bk)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr_s(input logic [31:0] d, input int lane);
        bs.wrequest = 1'b1;
        bs.wdata = d;
        #1;
        check("s_wready", bs.wready, 1);
        check("s_wlane", bs.wlane, lane);
        step();
        bs.wrequest = 1'b0;
    endtask
    task automatic wr_k(input logic [31:0] d, input int lane);
        bk.wrequest = 1'b1;
        bk.wdata = d;
        #1;
        check("k_wready", bk.wready, 1);
        check("k_wlane", bk.wlane, lane);
        step();
        bk.wrequest = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        init = 1'b0;
        bs.wrequest = 1'b0; bs.wdata = '0; bs.rrequest = '0;
        bk.wrequest = 1'b0; bk.wdata = '0; bk.rrequest = '0;
        step();
        step();
        check("rst_wready", bs.wready, 0);
        check("rst_wlane", bs.wlane, 0);
        check("rst_rready", bs.rready, 0);
        check("rst_rcount", bs.rcount, 0);
        rst = 1'b0;
        #1;
        check("post_rst_wready", bs.wready, 1);
        for (int k = 0; k < 8; k++) wr_s(32'hA0 + 32'(k), k % 4);
        #1;
        check("stream_rcount", bs.rcount, 8'hAA);
        check("stream_rready", bs.rready, 4'hF);
        check("stream_rdata", bs.rdata, 128'h000000A3_000000A2_000000A1_000000A0);
        check("full_wready", bs.wready, 0);
        check("full_wlane", bs.wlane, 0);
        bs.rrequest = 4'b1101;
        step();
        check("pop_head0", bs.rdata[31:0], 32'hA4);
        step();
        bs.rrequest = 4'b0000;
        #1;
        check("drain_rcount", bs.rcount, 8'h08);
        check("drain_rready", bs.rready, 4'b0010);
        wr_s(32'hB0, 0);
        check("b0_head", bs.rdata[31:0], 32'hB0);
        bs.rrequest = 4'b0001;
        step();
        bs.rrequest = 4'b0000;
        bs.wrequest = 1'b1;
        bs.wdata = 32'hC1;
        #1;
        check("stall0", bs.wready, 0);
        step();
        check("stall1", bs.wready, 0);
        check("stall_rcount", bs.rcount, 8'h08);
        bs.rrequest = 4'b0010;
        #1;
        check("stall_pop_cycle", bs.wready, 0);
        check("stall_head1", bs.rdata[63:32], 32'hA1);
        step();
        bs.rrequest = 4'b0000;
        #1;
        check("unstall_wready", bs.wready, 1);
        check("unstall_wlane", bs.wlane, 1);
        step();
        bs.wrequest = 1'b0;
        #1;
        check("c1_rcount", bs.rcount, 8'h08);
        check("c1_head1", bs.rdata[63:32], 32'hA5);
        bs.wrequest = 1'b1;
        bs.wdata = 32'hD0;
        init = 1'b1;
        #1;
        check("init_wready", bs.wready, 0);
        step();
        init = 1'b0;
        #1;
        check("init_rcount", bs.rcount, 8'h08);
        check("init_head1", bs.rdata[63:32], 32'hA5);
        check("init_wlane", bs.wlane, 0);
        step();
        bs.wrequest = 1'b0;
        #1;
        check("d0_rcount", bs.rcount, 8'h09);
        check("d0_head", bs.rdata[31:0], 32'hD0);
        for (int k = 0; k < 4; k++) begin
            init = 1'b1;
            step();
            init = 1'b0;
            check("pp_before", bs.rdata[31:0], k == 0 ? 32'hD0 : 32'hE0 + 32'(k - 1));
            bs.rrequest = 4'b0001;
            wr_s(32'hE0 + 32'(k), 0);
            bs.rrequest = 4'b0000;
            #1;
            check("pp_rcount", bs.rcount, 8'h09);
            check("pp_after", bs.rdata[31:0], 32'hE0 + 32'(k));
        end
        bs.rrequest = 4'b0010;
        step();
        check("lane1_order", bs.rdata[63:32], 32'hC1);
        step();
        bs.rrequest = 4'b0000;
        wr_s(32'hF1, 1);
        wr_s(32'hF2, 2);
        wr_s(32'hF3, 3);
        #1;
        check("part_rcount", bs.rcount, 8'h55);
        check("part_rready", bs.rready, 4'hF);
        check("part_rdata", bs.rdata, 128'h000000F3_000000F2_000000F1_000000E3);
        rst = 1'b1;
        #1;
        check("mid_rst_wready", bs.wready, 0);
        check("mid_rst_wlane", bs.wlane, 0);
        step();
        check("mid_rst_rready", bs.rready, 0);
        check("mid_rst_rcount", bs.rcount, 0);
        rst = 1'b0;
        #1;
        check("after_rst_wready", bs.wready, 1);
        check("after_rst_wlane", bs.wlane, 0);
        for (int k = 0; k < 7; k++) wr_k(32'h10 + 32'(k), k % 4);
        bk.rrequest = 4'b1001;
        step();
        bk.rrequest = 4'b0001;
        step();
        bk.rrequest = 4'b0000;
        #1;
        check("k_fill_rcount", bk.rcount, 8'h28);
        init = 1'b1;
        step();
        init = 1'b0;
        #1;
        check("k_init_wlane", bk.wlane, 0);
        step();
        check("k_idle_wlane", bk.wlane, 0);
        wr_k(32'h17, 0);
        bk.rrequest = 4'b0001;
        step();
        bk.rrequest = 4'b0000;
        #1;
        check("k_pre_rcount", bk.rcount, 8'h28);
        wr_k(32'h18, 3);
        #1;
        check("k_wrap_wlane", bk.wlane, 0);
        check("k_skip_rcount", bk.rcount, 8'h68);
        check("k_skip_head3", bk.rdata[127:96], 32'h18);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
